// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: sequential PC generation, a single-outstanding
// req/addr_ok/data_ok fetch port, and a small FIFO of {pc, inst} pairs that
// feeds decode through a valid/ready handshake. A redirect flushes and restarts.
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [5:0]  id_op,
    output logic [31:0] id_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } fetch_state_t;

    fetch_state_t  state;
    logic [31:0]   pc;
    logic [31:0]   req_pc;
    logic          discard;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_inst [DEPTH];

    logic          accept;
    logic          data_in;
    logic          push;
    logic          pop;

    // A request is accepted only while actually requesting; data is meaningful only
    // while waiting, so a stray data_ok after reset is ignored.
    assign accept  = (state == S_REQ) && inst_addr_ok;
    assign data_in = (state == S_WAIT) && inst_data_ok;
    // A returning word is kept only if no redirect has made it stale.
    assign push    = data_in && !discard && !redirect_valid;
    assign pop     = id_valid && id_ready;

    assign inst_req  = (state == S_REQ);
    assign inst_addr = pc;

    // Head of the FIFO is presented directly; zeros when empty.
    assign id_valid = (count != '0);
    assign id_inst  = id_valid ? mem_inst[rd_ptr] : 32'h0;
    assign id_pc    = id_valid ? mem_pc[rd_ptr]   : 32'h0;
    assign id_op    = id_inst[31:26];

    // Fetch sequencer: reserve a FIFO slot, request, wait for data, redirect PC.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            req_pc  <= 32'h0;
            discard <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Only one fetch is ever in flight, so a free slot now is a reserved slot.
                    if (count < FULL) begin
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (inst_addr_ok) begin
                        req_pc <= pc;
                        pc     <= pc + 32'd4;
                        state  <= S_WAIT;
                        if (redirect_valid) begin
                            discard <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        // The returning word is consumed here (pushed or dropped).
                        state   <= S_IDLE;
                        discard <= 1'b0;
                    end else if (redirect_valid) begin
                        discard <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            // A redirect overrides the sequential increment; unaccepted requests
            // simply continue with the new address.
            if (redirect_valid) begin
                pc <= redirect_pc & ~32'h3;
            end
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue after any pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage write port.
    // NOTE: the storage array has no reset; entries are only observed through
    // count, which is reset, and the outputs are forced to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= req_pc;
            mem_inst[wr_ptr] <= inst_rdata;
        end
    end

endmodule
